// File: rtl/uart_bus_regfile_if.sv
// Internal register bus between the UART-to-bus master and the register-file responder.
interface uart_bus_regfile_if;
   logic [15:0] int_address;
   logic [7:0]  int_wr_data;
   logic        int_write;
   logic        int_read;
   logic [7:0]  int_rd_data;
   logic        int_req;
   logic        int_gnt;

   modport master (
      output int_address, int_wr_data, int_write, int_read, int_req,
      input  int_rd_data, int_gnt
   );

   modport slave (
      input  int_address, int_wr_data, int_write, int_read, int_req,
      output int_rd_data, int_gnt
   );
endinterface

// File: rtl/uart_bus_regfile.sv
// Register-bus responder: grant arbitration against the LED engine, 8-bit config
// registers, registered reads, commit strobe and saturating protocol-error counter.
//
// state | meaning
// IDLE  | no grant; waits for int_req while the LED engine is not busy
// GRANT | master owns the bus until it drops int_req
module uart_bus_regfile #(
   parameter int          NUM_REGS  = 64,
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] CTRL_ADDR = 16'hFFFF
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   uart_bus_regfile_if.slave        bus,
   input  logic                     local_busy_i,
   output logic                     reg_commit_o,
   output logic [NUM_REGS*8-1:0]    reg_flat_o,
   output logic [7:0]               err_count_o
);

   localparam int          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [16:0] NUM_REGS_W = 17'(NUM_REGS);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_d;
   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] rd_data_q, rd_data_d;
   logic [7:0] err_q, err_d;
   logic       commit_q, commit_d;

   logic [15:0]      off;
   logic [IDX_W-1:0] idx;
   logic             gnt, in_range, is_ctrl, any_acc;
   logic             wr_en, rd_en, clr, err_evt;

   assign gnt      = (state_q == GRANT);
   assign off      = bus.int_address - BASE_ADDR;
   assign idx      = off[IDX_W-1:0];
   assign in_range = (bus.int_address >= BASE_ADDR) && ({1'b0, off} < NUM_REGS_W);
   assign is_ctrl  = (bus.int_address == CTRL_ADDR);
   assign any_acc  = bus.int_write | bus.int_read;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.int_req && !local_busy_i) state_d = GRANT;
         GRANT: if (!bus.int_req)                 state_d = IDLE;
      endcase
   end

   // A simultaneous write+read performs the write and drops the read.
   always_comb begin
      wr_en     = gnt & bus.int_write & in_range;
      rd_en     = gnt & bus.int_read & ~bus.int_write;
      clr       = gnt & bus.int_write & is_ctrl;
      err_evt   = (any_acc & ~gnt)
                | (gnt & any_acc & ~in_range & ~is_ctrl)
                | (bus.int_write & bus.int_read);
      commit_d  = clr;
      rd_data_d = rd_data_q;
      if (rd_en) begin
         if (in_range)     rd_data_d = regs_q[idx];
         else if (is_ctrl) rd_data_d = err_q;
         else              rd_data_d = 8'h00;
      end
      err_d = err_q;
      if (clr)                           err_d = 8'h00;
      else if (err_evt && err_q != 8'hFF) err_d = err_q + 8'h01;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         rd_data_q <= 8'h00;
         err_q     <= 8'h00;
         commit_q  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
         commit_q  <= commit_d;
         if (wr_en) regs_q[idx] <= bus.int_wr_data;
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign reg_flat_o[8*gi +: 8] = regs_q[gi];
   end

   assign bus.int_gnt     = gnt;
   assign bus.int_rd_data = rd_data_q;
   assign reg_commit_o    = commit_q;
   assign err_count_o     = err_q;

endmodule
